fp_normalizer: RTL and testbench

- Multi-cycle post-add/sub normalization stage. Sits directly downstream of the FP add/sub datapath.
- Consumes the raw result of the significand add or subtract: sign, aligned exponent, and an unnormalized 25-bit significand that includes carry and hidden bits.
- Shifts iteratively until the hidden bit is set, then packs an IEEE-754 single and flags exponent over/underflow.
- Uses a valid/ready handshake on both sides and processes one operation at a time.

---
 rtl/fp_normalizer.sv | 174 +++++++++++++++++
 tb/tb_fp_normalizer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// Post add/sub normalizer: iterative shift, IEEE-754 single pack, over/underflow flag.
// Define FP_NORMALIZER_ROUND_EN for round-half-even on the carry right-shift.
module fp_normalizer #(
    parameter int SIGNI       = 23,
    parameter int EXPO_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXPO_LENGTH-1:0] in_expo,
    input  logic [SIGNI+1:0]       in_signi,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out,
    output logic                   under_overflow,
    output logic                   busy
);

    localparam logic [EXPO_LENGTH-1:0] EMAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_SHIFT,
`ifdef FP_NORMALIZER_ROUND_EN
        S_ROUND,
`endif
        S_DONE
    } state_t;

    state_t                 r_state;
    logic                   r_sign;
    logic [EXPO_LENGTH-1:0] r_expo;
    logic [SIGNI+1:0]       r_signi;
    logic [31:0]            r_res;
    logic                   r_flag;

    logic [EXPO_LENGTH-1:0] w_expo_inc;
    logic [EXPO_LENGTH-1:0] w_expo_dec;
    logic [SIGNI+1:0]       w_rsh;
    logic [SIGNI+1:0]       w_lsh;
    logic [31:0]            w_zero;
    logic [31:0]            w_inf;

    assign w_expo_inc = r_expo + 1'b1;
    assign w_expo_dec = r_expo - 1'b1;
    assign w_rsh      = r_signi >> 1;
    assign w_lsh      = r_signi << 1;
    assign w_zero     = {r_sign, {(EXPO_LENGTH+SIGNI){1'b0}}};
    assign w_inf      = {r_sign, EMAX, {SIGNI{1'b0}}};

`ifdef FP_NORMALIZER_ROUND_EN
    logic [SIGNI+1:0] w_rnd;
    logic [SIGNI+1:0] w_rnd_sh;
    assign w_rnd    = r_signi + 1'b1;
    assign w_rnd_sh = w_rnd >> 1;
`endif

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);

    function automatic logic [31:0] f_pack(
        input logic                   s,
        input logic [EXPO_LENGTH-1:0] e,
        input logic [SIGNI+1:0]       m
    );
        return {s, e, m[SIGNI-1:0]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_sign         <= 1'b0;
            r_expo         <= '0;
            r_signi        <= '0;
            r_res          <= '0;
            r_flag         <= 1'b0;
            out            <= '0;
            out_valid      <= 1'b0;
            under_overflow <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign  <= in_sign;
                        r_expo  <= in_expo;
                        r_signi <= in_signi;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_state <= S_DONE;
                    r_flag  <= 1'b0;
                    if (r_signi == '0) begin
                        r_res <= w_zero;
                    end else if (r_expo == EMAX) begin
                        r_res  <= w_inf;
                        r_flag <= 1'b1;
                    end else if (r_signi[SIGNI+1]) begin
                        r_signi <= w_rsh;
                        r_expo  <= w_expo_inc;
                        if (w_expo_inc == EMAX) begin
                            r_res  <= w_inf;
                            r_flag <= 1'b1;
`ifdef FP_NORMALIZER_ROUND_EN
                        // guard bit and new LSB both set: round up next cycle
                        end else if (r_signi[0] & r_signi[1]) begin
                            r_state <= S_ROUND;
`endif
                        end else begin
                            r_res <= f_pack(r_sign, w_expo_inc, w_rsh);
                        end
                    end else if (r_signi[SIGNI]) begin
                        r_res <= f_pack(r_sign, r_expo, r_signi);
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // exponent saturates at zero; no denormals are produced
                    if (r_expo == '0) begin
                        r_res   <= w_zero;
                        r_flag  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_signi <= w_lsh;
                        r_expo  <= w_expo_dec;
                        if (w_lsh[SIGNI]) begin
                            r_res   <= f_pack(r_sign, w_expo_dec, w_lsh);
                            r_flag  <= 1'b0;
                            r_state <= S_DONE;
                        end else if (w_expo_dec == '0) begin
                            r_res   <= w_zero;
                            r_flag  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
`ifdef FP_NORMALIZER_ROUND_EN
                S_ROUND: begin
                    r_state <= S_DONE;
                    if (w_rnd[SIGNI+1]) begin
                        r_signi <= w_rnd_sh;
                        r_expo  <= w_expo_inc;
                        if (w_expo_inc == EMAX) begin
                            r_res  <= w_inf;
                            r_flag <= 1'b1;
                        end else begin
                            r_res <= f_pack(r_sign, w_expo_inc, w_rnd_sh);
                        end
                    end else begin
                        r_signi <= w_rnd;
                        r_res   <= f_pack(r_sign, r_expo, w_rnd);
                    end
                end
`endif
                S_DONE: begin
                    if (!out_valid) begin
                        out            <= r_res;
                        under_overflow <= r_flag;
                        out_valid      <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: directed plan vectors, random vectors,
// backpressure and mid-shift reset.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_expo = '0;
    logic [24:0] in_signi = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        under_overflow;
    logic        busy;

    fp_normalizer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_expo       (in_expo),
        .in_signi      (in_signi),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out           (out),
        .under_overflow(under_overflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] o;
        logic        f;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic s, input logic [7:0] e0,
                                  input logic [24:0] m0,
                                  output logic [31:0] o, output logic f,
                                  output int lat);
        logic [7:0]  e;
        logic [24:0] m;
`ifdef FP_NORMALIZER_ROUND_EN
        logic        g;
`endif
        e = e0;
        m = m0;
        lat = 2;
        f = 1'b0;
        o = {s, 31'b0};
        if (m == 0) begin
            o = {s, 31'b0};
        end else if (e == 8'hFF) begin
            o = {s, 8'hFF, 23'b0};
            f = 1'b1;
        end else if (m[24]) begin
`ifdef FP_NORMALIZER_ROUND_EN
            g = m[0];
`endif
            m = m >> 1;
            e = e + 8'd1;
            if (e != 8'hFF) begin
`ifdef FP_NORMALIZER_ROUND_EN
                if (g && m[0]) begin
                    lat = 3;
                    m = m + 25'd1;
                    if (m[24]) begin
                        m = m >> 1;
                        e = e + 8'd1;
                    end
                end
`endif
            end
            if (e == 8'hFF) begin
                o = {s, 8'hFF, 23'b0};
                f = 1'b1;
            end else begin
                o = {s, e, m[22:0]};
            end
        end else if (m[23]) begin
            o = {s, e, m[22:0]};
        end else begin
            for (int i = 0; i < 40; i++) begin
                lat++;
                if (e == 0) begin
                    f = 1'b1;
                    break;
                end
                m = m << 1;
                e = e - 8'd1;
                if (m[23]) begin
                    o = {s, e, m[22:0]};
                    break;
                end
                if (e == 0) begin
                    f = 1'b1;
                    break;
                end
            end
        end
    endfunction

    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [24:0] m, input logic [31:0] eo,
                          input logic ef, input int el, input int bp);
        exp_t x;
        int   k;
        x.o = eo;
        x.f = ef;
        x.lat = el;
        sb.push_back(x);
        in_sign  = s;
        in_expo  = e;
        in_signi = m;
        in_valid = 1'b1;
        chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 64) begin
            @(negedge clk);
            k++;
        end
        x = sb.pop_front();
        chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_out"}, out, x.o);
        chk({tag, "_flag"}, {31'b0, under_overflow}, {31'b0, x.f});
        chk({tag, "_lat"}, k, x.lat);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_nrdy"}, {31'b0, in_ready}, 32'd0);
        repeat (bp) begin
            in_valid = 1'b1;
            in_signi = 25'($urandom);
            in_expo  = 8'($urandom);
            @(negedge clk);
            chk({tag, "_bp_out"}, out, x.o);
            chk({tag, "_bp_flag"}, {31'b0, under_overflow}, {31'b0, x.f});
            chk({tag, "_bp_vld"}, {31'b0, out_valid}, 32'd1);
            chk({tag, "_bp_rdy"}, {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_xfer_vld"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_xfer_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_xfer_rdy"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] mo;
        logic        mf;
        int          ml;
        logic [24:0] one;
        logic [24:0] rm;
        int          pos;
        logic        rs;
        logic [7:0]  re;

        #1;
        chk("rst_out", out, 32'h0);
        chk("rst_vld", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_flag", {31'b0, under_overflow}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_rel_rdy", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        run_op("norm", 1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 1'b0, 2, 0);
        run_op("carry", 1'b0, 8'h7F, 25'h1000000, 32'h40000000, 1'b0, 2, 0);
`ifdef FP_NORMALIZER_ROUND_EN
        run_op("carry_rnd", 1'b0, 8'h7F, 25'h1000003, 32'h40000002, 1'b0, 3, 0);
        run_op("rnd_cout", 1'b0, 8'h7F, 25'h1FFFFFF, 32'h40800000, 1'b0, 3, 0);
`else
        run_op("carry_rnd", 1'b0, 8'h7F, 25'h1000003, 32'h40000001, 1'b0, 2, 0);
        run_op("rnd_cout", 1'b0, 8'h7F, 25'h1FFFFFF, 32'h407FFFFF, 1'b0, 2, 0);
`endif
        run_op("lshift", 1'b0, 8'h80, 25'h0200000, 32'h3F000000, 1'b0, 4, 0);
        run_op("zero", 1'b0, 8'h55, 25'h0000000, 32'h00000000, 1'b0, 2, 0);
        run_op("ovf", 1'b1, 8'hFE, 25'h1800000, 32'hFF800000, 1'b1, 2, 0);
        run_op("expmax", 1'b0, 8'hFF, 25'h0800000, 32'h7F800000, 1'b1, 2, 0);
        run_op("unf", 1'b0, 8'h02, 25'h0000001, 32'h00000000, 1'b1, 4, 0);
        run_op("bp", 1'b1, 8'h7F, 25'h0800000, 32'hBF800000, 1'b0, 2, 5);

        // mid-shift reset: out holds a nonzero result from the previous op
        run_op("pre_rst", 1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 1'b0, 2, 0);
        in_sign  = 1'b0;
        in_expo  = 8'h80;
        in_signi = 25'h0000010;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_out", out, 32'h0);
        chk("mid_rst_vld", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_rdy", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        run_op("post_rst", 1'b0, 8'h80, 25'h0200000, 32'h3F000000, 1'b0, 4, 0);

        one = 25'd1;
        for (int i = 0; i < 24; i++) begin
            rs  = 1'($urandom);
            re  = 8'($urandom);
            pos = $urandom_range(0, 25);
            if (pos == 25) begin
                rm = '0;
            end else begin
                rm = 25'($urandom);
                rm = (one << pos) | (rm & ((one << pos) - one));
            end
            model(rs, re, rm, mo, mf, ml);
            run_op("rand", rs, re, rm, mo, mf, ml, i % 5 == 0 ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
